// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared opcode/state encodings and defaults for mem_access_unit.
//  Revision    : 1.0
// ============================================================================
package mem_access_pkg;

    localparam int unsigned DEFAULT_DATA_W    = 16;
    localparam int unsigned DEFAULT_MEM_DEPTH = 256;
    localparam int unsigned ADDR_W            = 16;
    // Holds READ_LATENCY-1, and READ_LATENCY never exceeds 4.
    localparam int unsigned CNT_W             = 2;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Unsigned compare so high addresses never alias back into the array.
    function automatic logic is_fault(
        input logic [1:0]        op,
        input logic [ADDR_W-1:0] addr,
        input int unsigned       depth
    );
        return (op == OP_RSVD) || ({{(32-ADDR_W){1'b0}}, addr} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Single-outstanding LOAD/STORE/SWAP sequencer for DataMemory.
//  Revision    : 1.0
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned MEM_DEPTH    = DEFAULT_MEM_DEPTH,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [CNT_W-1:0] READ_CNT_INIT = CNT_W'(READ_LATENCY - 1);

    state_e              state_q;
    op_e                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rbuf_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_fault_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_LOAD;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q    <= op_e'(req_op);
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= READ_CNT_INIT;
                        if (is_fault(req_op, req_addr, MEM_DEPTH)) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_fault_q <= 1'b1;
                        end else if (op_e'(req_op) == OP_STORE) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    // mem_q is valid in the last READ cycle only.
                    if (cnt_q == '0) begin
                        if (op_q == OP_SWAP) begin
                            rbuf_q  <= mem_q;
                            state_q <= WRITE;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= mem_q;
                            rsp_fault_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= (op_q == OP_SWAP) ? rbuf_q : '0;
                    rsp_fault_q <= 1'b0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gated by reset so a reset landing in WRITE never commits the store.
    assign req_ready   = (state_q == IDLE)  && !reset;
    assign mem_wren    = (state_q == WRITE) && !reset;
    assign mem_address = addr_q;
    assign mem_data    = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_fault   = rsp_fault_q;

endmodule
`default_nettype wire
